// File: rtl/exe_stage_mc.sv
// exe_stage_mc: ARM-subset execute stage with Val2 shifter, ALU, branch target, multi-cycle MUL,
// NZCV register and EXE/MEM pipeline register. Optional operand forwarding: FORWARDING_EN.
module exe_stage_mc #(
    parameter int DATA_W     = 32,
    parameter int IMM_W      = 24,
    parameter int REG_W      = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              mem_freeze,
    input  logic [3:0]        exe_cmd,
    input  logic              mul_en,
    input  logic              s_en,
    input  logic              mem_read_en_in,
    input  logic              mem_write_en_in,
    input  logic              wb_en_in,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [IMM_W-1:0]  signed_imm,
    input  logic [REG_W-1:0]  dest_in,
`ifdef FORWARDING_EN
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] fwd_mem_val,
    input  logic [DATA_W-1:0] fwd_wb_val,
`endif
    output logic              out_valid,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic              wb_en,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DATA_W-1:0] br_addr,
    output logic [REG_W-1:0]  dest,
    output logic [3:0]        status_reg,
    output logic              busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input logic [5:0] amt);
        logic [2*DATA_W-1:0] dbl;
        dbl = {x, x} >> (amt % DATA_W);
        return dbl[DATA_W-1:0];
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [DATA_W-1:0] fwd_pick(input logic [1:0] sel, input logic [DATA_W-1:0] reg_v,
                                                   input logic [DATA_W-1:0] mem_v, input logic [DATA_W-1:0] wb_v);
        case (sel)
            2'b01:   return mem_v;
            2'b10:   return wb_v;
            default: return reg_v;
        endcase
    endfunction
`endif

    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic [DATA_W-1:0] w_val2;
    logic              w_sub_op;
    logic [DATA_W-1:0] w_b;
    logic              w_cin;
    logic [DATA_W:0]   w_sum;
    logic              w_ovf;
    logic [DATA_W-1:0] w_alu_res;
    logic [3:0]        w_alu_nzcv;
    logic              w_flag_upd;
    logic              w_is_arith;
    logic [DATA_W-1:0] w_off;
    logic [DATA_W-1:0] w_br;
    logic [DATA_W-1:0] w_mul_res;
    logic              w_accept;
    logic              w_mul_done;
    state_t            w_nxt_state;
    logic [CNT_W-1:0]  w_nxt_cnt;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_status;
    logic              r_out_valid;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_wb;
    logic [DATA_W-1:0] r_alu_res;
    logic [DATA_W-1:0] r_val_rm;
    logic [DATA_W-1:0] r_br_addr;
    logic [REG_W-1:0]  r_dest;
    logic [DATA_W-1:0] r_mul_a;
    logic [DATA_W-1:0] r_mul_b;
    logic [DATA_W-1:0] r_mul_rm;
    logic [DATA_W-1:0] r_mul_br;
    logic [REG_W-1:0]  r_mul_dest;
    logic              r_mul_s;
    logic              r_mul_rd;
    logic              r_mul_wr;
    logic              r_mul_wb;

`ifdef FORWARDING_EN
    assign w_src1 = fwd_pick(sel_src1, val_rn, fwd_mem_val, fwd_wb_val);
    assign w_src2 = fwd_pick(sel_src2, val_rm, fwd_mem_val, fwd_wb_val);
`else
    assign w_src1 = val_rn;
    assign w_src2 = val_rm;
`endif

    assign busy       = (r_state != ST_IDLE);
    assign in_ready   = !busy && !mem_freeze;
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_mul_done = (r_state == ST_DONE);

    // Val2 shifter: rotated immediate, load/store offset or shifted register
    always_comb begin
        w_val2 = {DATA_W{1'b0}};
        if (imm) begin
            w_val2 = rotr({{(DATA_W-8){1'b0}}, shift_operand[7:0]}, {1'b0, shift_operand[11:8], 1'b0});
        end else if (mem_read_en_in || mem_write_en_in) begin
            w_val2 = {{(DATA_W-12){1'b0}}, shift_operand};
        end else begin
            case (shift_operand[6:5])
                2'b00:   w_val2 = w_src2 << shift_operand[11:7];
                2'b01:   w_val2 = w_src2 >> shift_operand[11:7];
                2'b10:   w_val2 = $signed(w_src2) >>> shift_operand[11:7];
                2'b11:   w_val2 = rotr(w_src2, {1'b0, shift_operand[11:7]});
                default: w_val2 = w_src2;
            endcase
        end
    end

    // Subtraction is rn + ~val2 + 1, so C comes out directly as the no-borrow flag
    assign w_sub_op = (exe_cmd == CMD_SUB) || (exe_cmd == CMD_SBC);
    assign w_b      = w_sub_op ? ~w_val2 : w_val2;
    assign w_cin    = ((exe_cmd == CMD_ADC) || (exe_cmd == CMD_SBC)) ? r_status[1] : w_sub_op;
    assign w_sum    = {1'b0, w_src1} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};
    assign w_ovf    = (w_src1[DATA_W-1] == w_b[DATA_W-1]) && (w_sum[DATA_W-1] != w_src1[DATA_W-1]);

    // ALU result and candidate NZCV
    always_comb begin
        w_alu_res  = {DATA_W{1'b0}};
        w_flag_upd = 1'b1;
        w_is_arith = 1'b0;
        case (exe_cmd)
            CMD_MOV: w_alu_res = w_val2;
            CMD_MVN: w_alu_res = ~w_val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                w_alu_res  = w_sum[DATA_W-1:0];
                w_is_arith = 1'b1;
            end
            CMD_AND: w_alu_res = w_src1 & w_val2;
            CMD_ORR: w_alu_res = w_src1 | w_val2;
            CMD_EOR: w_alu_res = w_src1 ^ w_val2;
            default: w_flag_upd = 1'b0;
        endcase
        if (w_is_arith) begin
            w_alu_nzcv = {w_alu_res[DATA_W-1], (w_alu_res == {DATA_W{1'b0}}), w_sum[DATA_W], w_ovf};
        end else begin
            w_alu_nzcv = {w_alu_res[DATA_W-1], (w_alu_res == {DATA_W{1'b0}}), r_status[1:0]};
        end
    end

    assign w_off     = DATA_W'($signed(signed_imm));
    assign w_br      = pc + (w_off << 2'd2);
    assign w_mul_res = r_mul_a * r_mul_b;

    // Multiply FSM state and down-counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // Multiply FSM next state; DONE waits for the freeze to lift before retiring
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && mul_en) begin
                    w_nxt_state = ST_MUL;
                    w_nxt_cnt   = CNT_W'(MUL_CYCLES - 1);
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_MUL: begin
                w_nxt_cnt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_nxt_state = ST_DONE;
                end else begin
                    w_nxt_state = ST_MUL;
                end
            end
            ST_DONE: begin
                if (mem_freeze) begin
                    w_nxt_state = ST_DONE;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
        if (flush) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = {CNT_W{1'b0}};
        end else begin
            w_nxt_cnt = w_nxt_cnt;
        end
    end

    // Multiply operand and sideband capture at accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mul_a    <= {DATA_W{1'b0}};
            r_mul_b    <= {DATA_W{1'b0}};
            r_mul_rm   <= {DATA_W{1'b0}};
            r_mul_br   <= {DATA_W{1'b0}};
            r_mul_dest <= {REG_W{1'b0}};
            r_mul_s    <= 1'b0;
            r_mul_rd   <= 1'b0;
            r_mul_wr   <= 1'b0;
            r_mul_wb   <= 1'b0;
        end else if (w_accept && mul_en) begin
            r_mul_a    <= w_src1;
            r_mul_b    <= w_src2;
            r_mul_rm   <= w_src2;
            r_mul_br   <= w_br;
            r_mul_dest <= dest_in;
            r_mul_s    <= s_en;
            r_mul_rd   <= mem_read_en_in;
            r_mul_wr   <= mem_write_en_in;
            r_mul_wb   <= wb_en_in;
        end
    end

    // EXE/MEM pipeline register: flush > freeze > MUL retire > single-cycle op > bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb        <= 1'b0;
            r_alu_res   <= {DATA_W{1'b0}};
            r_val_rm    <= {DATA_W{1'b0}};
            r_br_addr   <= {DATA_W{1'b0}};
            r_dest      <= {REG_W{1'b0}};
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb        <= 1'b0;
        end else if (mem_freeze) begin
            r_out_valid <= r_out_valid;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_mem_read  <= r_mul_rd;
            r_mem_write <= r_mul_wr;
            r_wb        <= r_mul_wb;
            r_alu_res   <= w_mul_res;
            r_val_rm    <= r_mul_rm;
            r_br_addr   <= r_mul_br;
            r_dest      <= r_mul_dest;
        end else if (w_accept && !mul_en) begin
            r_out_valid <= 1'b1;
            r_mem_read  <= mem_read_en_in;
            r_mem_write <= mem_write_en_in;
            r_wb        <= wb_en_in;
            r_alu_res   <= w_alu_res;
            r_val_rm    <= w_src2;
            r_br_addr   <= w_br;
            r_dest      <= dest_in;
        end else begin
            r_out_valid <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb        <= 1'b0;
        end
    end

    // NZCV register; MUL only touches N and Z
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= 4'b0000;
        end else if (flush || mem_freeze) begin
            r_status <= r_status;
        end else if (w_mul_done && r_mul_s) begin
            r_status <= {w_mul_res[DATA_W-1], (w_mul_res == {DATA_W{1'b0}}), r_status[1:0]};
        end else if (w_accept && !mul_en && s_en && w_flag_upd) begin
            r_status <= w_alu_nzcv;
        end
    end

    assign out_valid    = r_out_valid;
    assign mem_read_en  = r_mem_read;
    assign mem_write_en = r_mem_write;
    assign wb_en        = r_wb;
    assign alu_res      = r_alu_res;
    assign val_rm_out   = r_val_rm;
    assign br_addr      = r_br_addr;
    assign dest         = r_dest;
    assign status_reg   = r_status;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed testbench for exe_stage_mc (default parameters), hand-computed expectations.
`timescale 1ns/1ps
module tb_exe_stage_mc;
    localparam int DATA_W = 32;
    localparam int IMM_W  = 24;
    localparam int REG_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, flush, mem_freeze, mul_en, s_en, imm;
    logic              mem_read_en_in, mem_write_en_in, wb_en_in;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] pc, val_rn, val_rm;
    logic [11:0]       shift_operand;
    logic [IMM_W-1:0]  signed_imm;
    logic [REG_W-1:0]  dest_in;
`ifdef FORWARDING_EN
    logic [1:0]        sel_src1, sel_src2;
    logic [DATA_W-1:0] fwd_mem_val, fwd_wb_val;
`endif
    logic              in_ready, out_valid, mem_read_en, mem_write_en, wb_en, busy;
    logic [DATA_W-1:0] alu_res, val_rm_out, br_addr;
    logic [REG_W-1:0]  dest;
    logic [3:0]        status_reg;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exe_stage_mc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .mem_freeze(mem_freeze), .exe_cmd(exe_cmd), .mul_en(mul_en), .s_en(s_en),
        .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in), .wb_en_in(wb_en_in),
        .pc(pc), .val_rn(val_rn), .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
        .signed_imm(signed_imm), .dest_in(dest_in),
`ifdef FORWARDING_EN
        .sel_src1(sel_src1), .sel_src2(sel_src2), .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val),
`endif
        .out_valid(out_valid), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .wb_en(wb_en),
        .alu_res(alu_res), .val_rm_out(val_rm_out), .br_addr(br_addr), .dest(dest),
        .status_reg(status_reg), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; flush = 1'b0; mem_freeze = 1'b0; mul_en = 1'b0; s_en = 1'b0; imm = 1'b0;
        mem_read_en_in = 1'b0; mem_write_en_in = 1'b0; wb_en_in = 1'b0; exe_cmd = 4'b0000;
        pc = 32'h0; val_rn = 32'h0; val_rm = 32'h0; shift_operand = 12'h000; signed_imm = 24'h0;
        dest_in = 4'h0;
`ifdef FORWARDING_EN
        sel_src1 = 2'b00; sel_src2 = 2'b00; fwd_mem_val = 32'h0; fwd_wb_val = 32'h0;
`endif
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic im, input logic [11:0] so, input logic s);
        in_valid = 1'b1; mul_en = 1'b0; exe_cmd = cmd; val_rn = rn; val_rm = rm;
        imm = im; shift_operand = so; s_en = s;
    endtask

    task automatic issue_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        in_valid = 1'b1; mul_en = 1'b1; exe_cmd = 4'b0000; val_rn = a; val_rm = b;
        imm = 1'b0; shift_operand = 12'h000; s_en = s;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        step(); step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (alu_res !== 32'h0) begin n_err++; $display("FAIL reset_alu_res got=%h exp=0", alu_res); end
        n_vec++; if (status_reg !== 4'b0000) begin n_err++; $display("FAIL reset_status got=%b exp=0000", status_reg); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_add_imm();
        issue(4'b0010, 32'd5, 32'h0, 1'b1, 12'h0FF, 1'b1);
        wb_en_in = 1'b1; dest_in = 4'd3;
        step();
        n_vec++; if (alu_res !== 32'd260) begin n_err++; $display("FAIL add_imm_res got=%0d exp=260", alu_res); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_imm_valid got=%b exp=1", out_valid); end
        n_vec++; if (status_reg !== 4'b0000) begin n_err++; $display("FAIL add_imm_nzcv got=%b exp=0000", status_reg); end
        n_vec++; if (wb_en !== 1'b1 || dest !== 4'd3) begin n_err++; $display("FAIL add_imm_ctrl got=%b/%0d exp=1/3", wb_en, dest); end
    endtask

    task automatic test_sub_adc();
        issue(4'b0100, 32'h8000_0000, 32'h1, 1'b0, 12'h000, 1'b1);
        step();
        n_vec++; if (alu_res !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sub_res got=%h exp=7fffffff", alu_res); end
        n_vec++; if (status_reg !== 4'b0011) begin n_err++; $display("FAIL sub_nzcv got=%b exp=0011", status_reg); end
        issue(4'b0011, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        step();
        n_vec++; if (alu_res !== 32'h1) begin n_err++; $display("FAIL adc_res got=%h exp=1", alu_res); end
        n_vec++; if (status_reg !== 4'b0011) begin n_err++; $display("FAIL adc_nzcv got=%b exp=0011", status_reg); end
    endtask

    task automatic test_shifts();
        logic [11:0] so_tab [5];
        logic [31:0] exp_tab [5];
        so_tab[0] = 12'h200; exp_tab[0] = 32'h0000_0010;
        so_tab[1] = 12'h220; exp_tab[1] = 32'h0800_0000;
        so_tab[2] = 12'h240; exp_tab[2] = 32'hF800_0000;
        so_tab[3] = 12'h260; exp_tab[3] = 32'h1800_0000;
        so_tab[4] = 12'h4FF; exp_tab[4] = 32'hFF00_0000;
        for (int i = 0; i < 5; i++) begin
            issue(4'b0001, 32'h0, 32'h8000_0001, (i == 4), so_tab[i], 1'b0);
            step();
            n_vec++; if (alu_res !== exp_tab[i]) begin n_err++; $display("FAIL shift_%0d got=%h exp=%h", i, alu_res, exp_tab[i]); end
        end
        issue(4'b1001, 32'h0, 32'h0, 1'b1, 12'h000, 1'b1);
        step();
        n_vec++; if (alu_res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mvn_res got=%h exp=ffffffff", alu_res); end
        n_vec++; if (status_reg !== 4'b1011) begin n_err++; $display("FAIL mvn_nzcv got=%b exp=1011", status_reg); end
    endtask

    task automatic test_load_store();
        issue(4'b0010, 32'h100, 32'h0, 1'b0, 12'hABC, 1'b0);
        mem_read_en_in = 1'b1; wb_en_in = 1'b1; dest_in = 4'd5;
        step();
        n_vec++; if (alu_res !== 32'hBBC) begin n_err++; $display("FAIL ldst_res got=%h exp=bbc", alu_res); end
        n_vec++; if (mem_read_en !== 1'b1 || dest !== 4'd5) begin n_err++; $display("FAIL ldst_ctrl got=%b/%0d exp=1/5", mem_read_en, dest); end
        mem_read_en_in = 1'b0;
    endtask

    task automatic test_logic();
        issue(4'b0110, 32'hF0F0, 32'hFF00, 1'b0, 12'h000, 1'b0);
        step();
        n_vec++; if (alu_res !== 32'hF000) begin n_err++; $display("FAIL and_res got=%h exp=f000", alu_res); end
        issue(4'b0111, 32'hF0F0, 32'h0F0F, 1'b0, 12'h000, 1'b0);
        step();
        n_vec++; if (alu_res !== 32'hFFFF) begin n_err++; $display("FAIL orr_res got=%h exp=ffff", alu_res); end
        issue(4'b1000, 32'hFFFF, 32'hFFFF, 1'b0, 12'h000, 1'b1);
        step();
        n_vec++; if (alu_res !== 32'h0) begin n_err++; $display("FAIL eor_res got=%h exp=0", alu_res); end
        n_vec++; if (status_reg !== 4'b0111) begin n_err++; $display("FAIL eor_nzcv got=%b exp=0111", status_reg); end
        issue(4'b1111, 32'd5, 32'd3, 1'b0, 12'h000, 1'b1);
        step();
        n_vec++; if (alu_res !== 32'h0) begin n_err++; $display("FAIL badcmd_res got=%h exp=0", alu_res); end
        n_vec++; if (status_reg !== 4'b0111) begin n_err++; $display("FAIL badcmd_nzcv got=%b exp=0111", status_reg); end
    endtask

    task automatic test_mul();
        issue_mul(32'd7, 32'd6, 1'b1);
        step();
        in_valid = 1'b0; mul_en = 1'b0;
        n_vec++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL mul_busy0 got=%b/%b exp=0/1", in_ready, busy); end
        for (int i = 1; i < 4; i++) begin
            step();
            n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL mul_wait_%0d got=%b/%b exp=0/0", i, in_ready, out_valid); end
        end
        step();
        n_vec++; if (out_valid !== 1'b1 || alu_res !== 32'd42) begin n_err++; $display("FAIL mul_res got=%b/%0d exp=1/42", out_valid, alu_res); end
        n_vec++; if (status_reg !== 4'b0011 || in_ready !== 1'b1) begin n_err++; $display("FAIL mul_flags got=%b/%b exp=0011/1", status_reg, in_ready); end
    endtask

    task automatic test_flush_mul();
        issue_mul(32'd0, 32'd5, 1'b1);
        step();
        in_valid = 1'b0; mul_en = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_mul got=%b/%b exp=0/0", busy, out_valid); end
        n_vec++; if (status_reg !== 4'b0011) begin n_err++; $display("FAIL flush_mul_nzcv got=%b exp=0011", status_reg); end
        step(); step(); step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_mul_late got=%b exp=0", out_valid); end
    endtask

    task automatic test_freeze();
        issue(4'b0010, 32'd10, 32'd20, 1'b0, 12'h000, 1'b0);
        wb_en_in = 1'b1;
        step();
        mem_freeze = 1'b1;
        issue(4'b0010, 32'd1, 32'd1, 1'b0, 12'h000, 1'b1);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL freeze_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (alu_res !== 32'd30 || out_valid !== 1'b1) begin n_err++; $display("FAIL freeze_hold_%0d got=%0d/%b exp=30/1", i, alu_res, out_valid); end
        end
        mem_freeze = 1'b0; in_valid = 1'b0;
        step();
        n_vec++; if (out_valid !== 1'b0 || wb_en !== 1'b0 || alu_res !== 32'd30) begin n_err++; $display("FAIL bubble got=%b/%b/%0d exp=0/0/30", out_valid, wb_en, alu_res); end
        n_vec++; if (status_reg !== 4'b0011) begin n_err++; $display("FAIL freeze_nzcv got=%b exp=0011", status_reg); end
        wb_en_in = 1'b0;
    endtask

    task automatic test_branch();
        logic [31:0] pc_tab [3];
        logic [23:0] off_tab [3];
        logic [31:0] exp_tab [3];
        pc_tab[0] = 32'h100;  off_tab[0] = 24'hFFFFFF; exp_tab[0] = 32'hFC;
        pc_tab[1] = 32'h0;    off_tab[1] = 24'hFFFFFF; exp_tab[1] = 32'hFFFF_FFFC;
        pc_tab[2] = 32'h1000; off_tab[2] = 24'h000003; exp_tab[2] = 32'h100C;
        for (int i = 0; i < 3; i++) begin
            issue(4'b0001, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
            pc = pc_tab[i]; signed_imm = off_tab[i];
            step();
            n_vec++; if (br_addr !== exp_tab[i]) begin n_err++; $display("FAIL br_addr_%0d got=%h exp=%h", i, br_addr, exp_tab[i]); end
        end
    endtask

    task automatic test_flush_same();
        issue(4'b0010, 32'h0, 32'h0, 1'b0, 12'h000, 1'b1);
        wb_en_in = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; wb_en_in = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || wb_en !== 1'b0) begin n_err++; $display("FAIL flush_drop got=%b/%b exp=0/0", out_valid, wb_en); end
        n_vec++; if (status_reg !== 4'b0011) begin n_err++; $display("FAIL flush_drop_nzcv got=%b exp=0011", status_reg); end
    endtask

    task automatic test_mul_freeze();
        issue_mul(32'd5, 32'd5, 1'b0);
        step();
        in_valid = 1'b0; mul_en = 1'b0;
        step(); step();
        mem_freeze = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL mul_frz_%0d got=%b/%b exp=1/0", i, busy, out_valid); end
        end
        mem_freeze = 1'b0;
        step();
        n_vec++; if (out_valid !== 1'b1 || alu_res !== 32'd25 || busy !== 1'b0) begin n_err++; $display("FAIL mul_frz_rel got=%b/%0d/%b exp=1/25/0", out_valid, alu_res, busy); end
    endtask

`ifdef FORWARDING_EN
    task automatic test_forwarding();
        issue(4'b0010, 32'd100, 32'd0, 1'b0, 12'h000, 1'b0);
        sel_src1 = 2'b01; fwd_mem_val = 32'd9;
        step();
        n_vec++; if (alu_res !== 32'd9) begin n_err++; $display("FAIL fwd_mem got=%0d exp=9", alu_res); end
        issue(4'b0010, 32'd1, 32'd77, 1'b0, 12'h000, 1'b0);
        sel_src1 = 2'b00; sel_src2 = 2'b10; fwd_wb_val = 32'd4;
        step();
        n_vec++; if (alu_res !== 32'd5) begin n_err++; $display("FAIL fwd_wb got=%0d exp=5", alu_res); end
        sel_src2 = 2'b00; in_valid = 1'b0;
        step();
    endtask
`endif

    task automatic test_reset_mid_mul();
        issue_mul(32'd3, 32'd3, 1'b1);
        step();
        in_valid = 1'b0; mul_en = 1'b0;
        step();
        rst = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || status_reg !== 4'b0000) begin n_err++; $display("FAIL rst_mid_mul got=%b/%b exp=0/0000", busy, status_reg); end
        step();
        rst = 1'b1;
        step(); step(); step(); step();
        n_vec++; if (out_valid !== 1'b0 || alu_res !== 32'h0) begin n_err++; $display("FAIL rst_mid_mul_out got=%b/%h exp=0/0", out_valid, alu_res); end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_sub_adc();
        test_shifts();
        test_load_store();
        test_logic();
        in_valid = 1'b0;
        step();
        test_mul();
        test_flush_mul();
        test_freeze();
        test_branch();
        test_flush_same();
        in_valid = 1'b0;
        step();
        test_mul_freeze();
`ifdef FORWARDING_EN
        test_forwarding();
`endif
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
